// File: rtl/hex_display_ctrl.sv
// Six-digit active-low seven-segment controller with valid/ready load, DP and blink per digit.
// Define HEX_DISPLAY_DEC_EN to build the decimal (double-dabble) path; otherwise every load is hex.
//
// state | meaning
// IDLE  | ready; hex transfers load the display directly
// CONV  | double-dabble iterations for a decimal transfer (decimal build only)
// LOAD  | decimal result (or dashes) loaded into the display registers
module hex_display_ctrl #(
    parameter int BLINK_DIV = 25000000,
    parameter int LZ_BLANK  = 0
) (
    input  logic        MAX10_CLK1_50,
    input  logic        RESET_N,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [23:0] in_data,
    input  logic        in_dec,
    input  logic [5:0]  dp_mask,
    input  logic [5:0]  blink_mask,
    output logic [7:0]  HEX0,
    output logic [7:0]  HEX1,
    output logic [7:0]  HEX2,
    output logic [7:0]  HEX3,
    output logic [7:0]  HEX4,
    output logic [7:0]  HEX5
);

    localparam int CW = $clog2(BLINK_DIV);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        LOAD = 2'd2
    } state_t;

    state_t         state, state_next;
    logic           ready_q, ready_next;
    logic           xfer;
    logic           load_hex;
    logic [23:0]    dig_q;
    logic [5:0]     dp_q;
    logic [5:0]     blink_q;
    logic           dash_q;
    logic [CW-1:0]  blink_cnt;
    logic           phase_q;
    logic [5:0]     blank;
    logic [47:0]    hex_d;
    logic [47:0]    hex_q;

`ifdef HEX_DISPLAY_DEC_EN
    logic           start_conv;
    logic           load_dec;
    logic [43:0]    dd_q;
    logic [43:0]    dd_step;
    logic [4:0]     iter_q;
    logic           over_q;
    logic [5:0]     cap_dp_q;
    logic [5:0]     cap_blink_q;

    function automatic logic [23:0] add3(input logic [23:0] b);
        logic [23:0] r;
        r = b;
        for (int i = 0; i < 6; i++) begin
            if (b[4*i +: 4] >= 4'd5)
                r[4*i +: 4] = b[4*i +: 4] + 4'd3;
        end
        return r;
    endfunction

    assign dd_step = {add3(dd_q[43:20]), dd_q[19:0]};
`else
    logic unused_dec;
    assign unused_dec = in_dec;
`endif

    function automatic logic [7:0] enc(input logic [3:0] d);
        case (d)
            4'h0: enc = 8'hC0;
            4'h1: enc = 8'hF9;
            4'h2: enc = 8'hA4;
            4'h3: enc = 8'hB0;
            4'h4: enc = 8'h99;
            4'h5: enc = 8'h92;
            4'h6: enc = 8'h82;
            4'h7: enc = 8'hF8;
            4'h8: enc = 8'h80;
            4'h9: enc = 8'h90;
            4'hA: enc = 8'h88;
            4'hB: enc = 8'h83;
            4'hC: enc = 8'hC6;
            4'hD: enc = 8'hA1;
            4'hE: enc = 8'h86;
            default: enc = 8'h8E;
        endcase
    endfunction

    assign xfer     = in_valid && ready_q;
    assign in_ready = ready_q;

    always_ff @(posedge MAX10_CLK1_50) begin
        if (!RESET_N) begin
            state   <= IDLE;
            ready_q <= 1'b0;
        end else begin
            state   <= state_next;
            ready_q <= ready_next;
        end
    end

    always_comb begin
        state_next = state;
        ready_next = 1'b1;
        load_hex   = 1'b0;
`ifdef HEX_DISPLAY_DEC_EN
        start_conv = 1'b0;
        load_dec   = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (xfer) begin
`ifdef HEX_DISPLAY_DEC_EN
                    if (in_dec) begin
                        start_conv = 1'b1;
                        ready_next = 1'b0;
                        state_next = CONV;
                    end else begin
                        load_hex = 1'b1;
                    end
`else
                    load_hex = 1'b1;
`endif
                end
            end
`ifdef HEX_DISPLAY_DEC_EN
            CONV: begin
                ready_next = 1'b0;
                if (iter_q == 5'd19)
                    state_next = LOAD;
            end
            LOAD: begin
                load_dec   = 1'b1;
                state_next = IDLE;
            end
`endif
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge MAX10_CLK1_50) begin
        if (!RESET_N) begin
            dig_q       <= '0;
            dp_q        <= '0;
            blink_q     <= '0;
            dash_q      <= 1'b0;
`ifdef HEX_DISPLAY_DEC_EN
            dd_q        <= '0;
            iter_q      <= '0;
            over_q      <= 1'b0;
            cap_dp_q    <= '0;
            cap_blink_q <= '0;
`endif
        end else begin
            if (load_hex) begin
                dig_q   <= in_data;
                dp_q    <= dp_mask;
                blink_q <= blink_mask;
                dash_q  <= 1'b0;
            end
`ifdef HEX_DISPLAY_DEC_EN
            if (start_conv) begin
                dd_q        <= {24'd0, in_data[19:0]};
                iter_q      <= '0;
                over_q      <= (in_data[19:0] > 20'd999999);
                cap_dp_q    <= dp_mask;
                cap_blink_q <= blink_mask;
            end else if (state == CONV) begin
                dd_q   <= {dd_step[42:0], 1'b0};
                iter_q <= iter_q + 5'd1;
            end
            if (load_dec) begin
                dig_q   <= dd_q[43:20];
                dp_q    <= cap_dp_q;
                blink_q <= cap_blink_q;
                dash_q  <= over_q;
            end
`endif
        end
    end

    // Free-running blink timebase, unaffected by transfers.
    always_ff @(posedge MAX10_CLK1_50) begin
        if (!RESET_N) begin
            blink_cnt <= '0;
            phase_q   <= 1'b0;
        end else if (blink_cnt == CW'(BLINK_DIV - 1)) begin
            blink_cnt <= '0;
            phase_q   <= ~phase_q;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end

    always_comb begin
        logic       lead;
        logic [7:0] seg;
        blank = '0;
        hex_d = '0;
        lead  = 1'b1;
        for (int i = 5; i >= 1; i--) begin
            lead     = lead && (dig_q[4*i +: 4] == 4'd0);
            blank[i] = (LZ_BLANK != 0) && !dash_q && lead;
        end
        for (int i = 0; i < 6; i++) begin
            seg = dash_q ? 8'hBF : enc(dig_q[4*i +: 4]);
            if (blank[i])
                seg = 8'hFF;
            if (dp_q[i])
                seg[7] = 1'b0;
            if (phase_q && blink_q[i])
                seg = 8'hFF;
            hex_d[8*i +: 8] = seg;
        end
    end

    always_ff @(posedge MAX10_CLK1_50) begin
        if (!RESET_N)
            hex_q <= {6{8'hFF}};
        else
            hex_q <= hex_d;
    end

    assign HEX0 = hex_q[7:0];
    assign HEX1 = hex_q[15:8];
    assign HEX2 = hex_q[23:16];
    assign HEX3 = hex_q[31:24];
    assign HEX4 = hex_q[39:32];
    assign HEX5 = hex_q[47:40];

endmodule

// File: tb/tb_hex_display_ctrl.sv
// Directed bench for hex_display_ctrl: one instance without and one with leading-zero blanking.
// Decimal checks are built when HEX_DISPLAY_DEC_EN is defined.
module tb_hex_display_ctrl;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [23:0] in_data;
    logic        in_dec;
    logic [5:0]  dp_mask;
    logic [5:0]  blink_mask;
    logic        ready_a, ready_b;
    logic [7:0]  a0, a1, a2, a3, a4, a5;
    logic [7:0]  b0, b1, b2, b3, b4, b5;
    logic [47:0] hexa, hexb;
    int          checks = 0;
    int          errors = 0;
    int          ecount = 0;

    hex_display_ctrl #(.BLINK_DIV(4), .LZ_BLANK(0)) dut_a (
        .MAX10_CLK1_50(clk), .RESET_N(rst_n), .in_valid(in_valid), .in_ready(ready_a),
        .in_data(in_data), .in_dec(in_dec), .dp_mask(dp_mask), .blink_mask(blink_mask),
        .HEX0(a0), .HEX1(a1), .HEX2(a2), .HEX3(a3), .HEX4(a4), .HEX5(a5)
    );

    hex_display_ctrl #(.BLINK_DIV(4), .LZ_BLANK(1)) dut_b (
        .MAX10_CLK1_50(clk), .RESET_N(rst_n), .in_valid(in_valid), .in_ready(ready_b),
        .in_data(in_data), .in_dec(in_dec), .dp_mask(dp_mask), .blink_mask(blink_mask),
        .HEX0(b0), .HEX1(b1), .HEX2(b2), .HEX3(b3), .HEX4(b4), .HEX5(b5)
    );

    assign hexa = {a5, a4, a3, a2, a1, a0};
    assign hexb = {b5, b4, b3, b2, b1, b0};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edges seen with reset released, for the blink phase model.
    always @(posedge clk) begin
        if (!rst_n) ecount <= 0;
        else        ecount <= ecount + 1;
    end

    task automatic tick(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [23:0] d, input logic dec, input logic [5:0] dp, input logic [5:0] bl);
        in_valid   = 1'b1;
        in_data    = d;
        in_dec     = dec;
        dp_mask    = dp;
        blink_mask = bl;
        tick();
        in_valid   = 1'b0;
        in_dec     = 1'b0;
    endtask

    initial begin
        logic [7:0] exp5;
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_data    = '0;
        in_dec     = 1'b0;
        dp_mask    = '0;
        blink_mask = '0;

        for (int i = 0; i < 3; i++) begin
            tick();
            chk("reset_hex_a", hexa, {6{8'hFF}});
            chk("reset_hex_b", hexb, {6{8'hFF}});
            chk("reset_ready", {46'd0, ready_a, ready_b}, 48'd0);
        end
        rst_n = 1'b1;
        tick();
        chk("ready_after_release", {46'd0, ready_a, ready_b}, 48'd3);
        chk("cleared_a", hexa, {6{8'hC0}});
        chk("cleared_lz_b", hexb, 48'hFFFF_FFFF_FFC0);

        send(24'h12AB0F, 1'b0, 6'b000001, 6'b0);
        chk("hex_same_edge", hexa, {6{8'hC0}});
        chk("hex_ready_kept", {47'd0, ready_a}, 48'd1);
        tick();
        chk("hex_12ab0f_a", hexa, 48'hF9A4_8883_C00E);
        chk("hex_12ab0f_b", hexb, 48'hF9A4_8883_C00E);

        in_valid = 1'b1; in_data = 24'h000050; dp_mask = 6'b0;
        tick();
        in_data = 24'h000000; dp_mask = 6'b100000;
        tick();
        in_valid = 1'b0;
        chk("b2b_first_a", hexa, 48'hC0C0_C0C0_92C0);
        chk("b2b_first_lz_b", hexb, 48'hFFFF_FFFF_92C0);
        tick();
        chk("b2b_zero_dp_a", hexa, 48'h40C0_C0C0_C0C0);
        chk("zero_lz_dp_b", hexb, 48'h7FFF_FFFF_FFC0);

        send(24'h654321, 1'b0, 6'b0, 6'b100000);
        blink_mask = 6'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            exp5 = (((ecount - 1) / 4) % 2 == 1) ? 8'hFF : 8'h82;
            chk("blink_hex5", hexa, {exp5, 40'h9299_B0A4_F9});
        end
        send(24'h000000, 1'b0, 6'b0, 6'b0);
        tick();

`ifdef HEX_DISPLAY_DEC_EN
        send(24'h01E240, 1'b1, 6'b0, 6'b0);
        in_valid = 1'b1; in_data = 24'hFFFFFF;
        chk("dec_ready_low_0", {47'd0, ready_a}, 48'd0);
        for (int i = 1; i <= 20; i++) begin
            tick();
            chk("dec_ready_low", {47'd0, ready_a}, 48'd0);
        end
        in_valid = 1'b0;
        tick();
        chk("dec_ready_back", {47'd0, ready_a}, 48'd1);
        chk("dec_hex_not_yet", hexa, {6{8'hC0}});
        tick();
        chk("dec_123456_a", hexa, 48'hF9A4_B099_9282);

        send(24'h0F4240, 1'b1, 6'b0, 6'b0);
        tick(22);
        chk("dec_overflow_a", hexa, {6{8'hBF}});
        chk("dec_overflow_b", hexb, {6{8'hBF}});

        send(24'h0F423F, 1'b1, 6'b0, 6'b0);
        tick(22);
        chk("dec_999999_a", hexa, {6{8'h90}});

        send(24'h000032, 1'b1, 6'b0, 6'b0);
        tick(22);
        chk("dec_50_a", hexa, 48'hC0C0_C0C0_92C0);
        chk("dec_50_lz_b", hexb, 48'hFFFF_FFFF_92C0);
`else
        send(24'h123456, 1'b1, 6'b0, 6'b0);
        chk("nodec_ready_kept", {47'd0, ready_a}, 48'd1);
        tick();
        chk("nodec_as_hex_a", hexa, 48'hF9A4_B099_9282);
`endif

        send(24'h01E240, 1'b1, 6'b0, 6'b0);
        tick(10);
        rst_n = 1'b0;
        tick();
        chk("midreset_dark", hexa, {6{8'hFF}});
        chk("midreset_ready", {47'd0, ready_a}, 48'd0);
        rst_n = 1'b1;
        tick();
        chk("midreset_release", {47'd0, ready_a}, 48'd1);
        chk("midreset_cleared", hexa, {6{8'hC0}});
        tick(25);
        chk("midreset_no_stale", hexa, {6{8'hC0}});
        send(24'hFFFFFF, 1'b0, 6'b0, 6'b0);
        tick();
        chk("after_reset_fff_a", hexa, {6{8'h8E}});
        chk("after_reset_fff_b", hexb, {6{8'h8E}});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
